// File: rtl/clk_seq_pkg.sv
// Shared types and constants for the 2x clock generator reset/lock sequencer.
package clk_seq_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RELEASE   = 3'd3,
      RUN       = 3'd4,
      FAIL      = 3'd5
   } clk_seq_state_e;

   localparam int unsigned LOST_W = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/clk_seq_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset to 0.
module clk_seq_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/clk_lock_rst_seq.sv
// Reset and lock sequencer: drives the generator reset, qualifies lock, and releases
// peripheral then core resets; recovers from lock loss and retries failed locks.
module clk_lock_rst_seq
   import clk_seq_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 4096,
   parameter int unsigned STABLE_CYCLES  = 256,
   parameter int unsigned STAGGER_CYCLES = 8,
   parameter int unsigned RETRY_MAX      = 3
) (
   input  logic              clk_in1,
   input  logic              resetn,
   input  logic              locked,
   input  logic              relock_req,
   output logic              pll_resetn,
   output logic              clk_en,
   output logic              periph_resetn,
   output logic              core_resetn,
   output logic              relock_ack,
   output logic              fail,
   output logic [LOST_W-1:0] lost_count,
   output logic [2:0]        state
);

   localparam int unsigned CntMax = max_u(max_u(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                          max_u(STABLE_CYCLES, STAGGER_CYCLES));
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned RetryW = $clog2(RETRY_MAX + 1);

   clk_seq_state_e    state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [RetryW-1:0] retry_q, retry_d, retry_inc;
   logic              pending_q, pending_d;
   logic [LOST_W-1:0] lost_q, lost_d;
   logic              locked_s;
   logic              ack_d, pll_resetn_d, released_d, core_resetn_d, fail_d;

   clk_seq_sync2 u_lock_sync (
      .clk   (clk_in1),
      .rst_n (resetn),
      .d     (locked),
      .q     (locked_s)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      retry_d   = retry_q;
      retry_inc = retry_q + RetryW'(1);
      pending_d = pending_q | relock_req;
      lost_d    = lost_q;
      ack_d     = 1'b0;

      unique case (state_q)
         PLL_RST: begin
            if (cnt_q == '0) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_d = STABLE;
            end else if (cnt_q == '0) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RetryW'(RETRY_MAX)) ? FAIL : PLL_RST;
            end
         end
         STABLE: begin
            if (!locked_s)         state_d = WAIT_LOCK;
            else if (cnt_q == '0)  state_d = RELEASE;
         end
         RELEASE, RUN: begin
            // Loss takes priority over a simultaneous relock request (pending still set above).
            if (!locked_s) begin
               if (lost_q != '1) lost_d = lost_q + LOST_W'(1);
               state_d = PLL_RST;
            end else if (state_q == RUN && relock_req) begin
               state_d = PLL_RST;
            end else if (state_q == RELEASE && cnt_q == '0) begin
               state_d = RUN;
            end
         end
         FAIL: begin
            if (relock_req) begin
               retry_d = '0;
               state_d = PLL_RST;
            end
         end
         default: state_d = PLL_RST;
      endcase

      if (state_d == RUN) begin
         retry_d   = '0;
         ack_d     = pending_d;
         pending_d = 1'b0;
      end

      // Shared down-counter: reload on every state change, otherwise count toward zero.
      if (state_d != state_q) begin
         case (state_d)
            PLL_RST:   cnt_d = CntW'(PLL_RST_CYCLES - 1);
            WAIT_LOCK: cnt_d = CntW'(LOCK_TIMEOUT - 1);
            STABLE:    cnt_d = CntW'(STABLE_CYCLES - 1);
            RELEASE:   cnt_d = CntW'(STAGGER_CYCLES - 1);
            default:   cnt_d = '0;
         endcase
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CntW'(1);
      end

      pll_resetn_d  = (state_d != PLL_RST) && (state_d != FAIL);
      released_d    = (state_d == RELEASE) || (state_d == RUN);
      core_resetn_d = (state_d == RUN);
      fail_d        = (state_d == FAIL);
   end

   always_ff @(posedge clk_in1 or negedge resetn) begin
      if (!resetn) begin
         state_q       <= PLL_RST;
         cnt_q         <= CntW'(PLL_RST_CYCLES - 1);
         retry_q       <= '0;
         pending_q     <= 1'b0;
         lost_q        <= '0;
         pll_resetn    <= 1'b0;
         clk_en        <= 1'b0;
         periph_resetn <= 1'b0;
         core_resetn   <= 1'b0;
         relock_ack    <= 1'b0;
         fail          <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         retry_q       <= retry_d;
         pending_q     <= pending_d;
         lost_q        <= lost_d;
         pll_resetn    <= pll_resetn_d;
         clk_en        <= released_d;
         periph_resetn <= released_d;
         core_resetn   <= core_resetn_d;
         relock_ack    <= ack_d;
         fail          <= fail_d;
      end
   end

   assign lost_count = lost_q;
   assign state      = state_q;

endmodule

// File: tb/tb_clk_lock_rst_seq.sv
// Bench for clk_lock_rst_seq: directed table, corner sequences and random lock
// activity, all compared every cycle against a deadline-based reference model.
module tb_clk_lock_rst_seq;

   localparam int P = 4;
   localparam int T = 32;
   localparam int S = 8;
   localparam int G = 3;
   localparam int R = 2;

   localparam int PH_RST    = 0;
   localparam int PH_WAIT   = 1;
   localparam int PH_STABLE = 2;
   localparam int PH_REL    = 3;
   localparam int PH_RUN    = 4;
   localparam int PH_FAIL   = 5;

   logic       clk_in1 = 1'b0;
   logic       resetn = 1'b0;
   logic       locked = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_resetn, clk_en, periph_resetn, core_resetn, relock_ack, fail;
   logic [7:0] lost_count;
   logic [2:0] state;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk_in1 = ~clk_in1;

   clk_lock_rst_seq #(
      .PLL_RST_CYCLES (P),
      .LOCK_TIMEOUT   (T),
      .STABLE_CYCLES  (S),
      .STAGGER_CYCLES (G),
      .RETRY_MAX      (R)
   ) dut (
      .clk_in1       (clk_in1),
      .resetn        (resetn),
      .locked        (locked),
      .relock_req    (relock_req),
      .pll_resetn    (pll_resetn),
      .clk_en        (clk_en),
      .periph_resetn (periph_resetn),
      .core_resetn   (core_resetn),
      .relock_ack    (relock_ack),
      .fail          (fail),
      .lost_count    (lost_count),
      .state         (state)
   );

   // Reference model: phase plus an absolute end-cycle deadline; locked history in a queue.
   int m_ph, m_now, m_end, m_retry, m_lost;
   bit m_pend, m_ack;
   bit q_lock[$];

   function automatic int dur(input int ph);
      case (ph)
         PH_RST:    return P;
         PH_WAIT:   return T;
         PH_STABLE: return S;
         PH_REL:    return G;
         default:   return 0;
      endcase
   endfunction

   task automatic model_reset();
      m_ph = PH_RST; m_now = -1; m_end = -1 + P; m_retry = 0; m_lost = 0;
      m_pend = 0; m_ack = 0;
      q_lock.delete();
   endtask

   task automatic model_edge();
      int nph;
      bit ls;
      m_now++;
      ls = (q_lock.size() >= 2) ? q_lock[q_lock.size()-2] : 1'b0;
      nph = m_ph;
      m_ack = 0;
      if (relock_req) m_pend = 1;
      case (m_ph)
         PH_RST: if (m_now == m_end) nph = PH_WAIT;
         PH_WAIT: begin
            if (ls) nph = PH_STABLE;
            else if (m_now == m_end) begin
               m_retry++;
               nph = (m_retry == R) ? PH_FAIL : PH_RST;
            end
         end
         PH_STABLE: if (!ls) nph = PH_WAIT; else if (m_now == m_end) nph = PH_REL;
         PH_REL, PH_RUN: begin
            if (!ls) begin
               m_lost = (m_lost < 255) ? m_lost + 1 : 255;
               nph = PH_RST;
            end else if (m_ph == PH_RUN && relock_req) nph = PH_RST;
            else if (m_ph == PH_REL && m_now == m_end) nph = PH_RUN;
         end
         PH_FAIL: if (relock_req) begin m_retry = 0; nph = PH_RST; end
         default: ;
      endcase
      if (nph == PH_RUN) begin
         m_retry = 0;
         m_ack = m_pend;
         m_pend = 0;
      end
      if (nph != m_ph) m_end = m_now + dur(nph);
      m_ph = nph;
      q_lock.push_back(locked);
      if (q_lock.size() > 2) void'(q_lock.pop_front());
   endtask

   function automatic logic [16:0] model_vec();
      logic pll, rel;
      pll = (m_ph != PH_RST) && (m_ph != PH_FAIL);
      rel = (m_ph == PH_REL) || (m_ph == PH_RUN);
      return {3'(m_ph), pll, rel, rel, m_ph == PH_RUN, m_ack, m_ph == PH_FAIL, 8'(m_lost)};
   endfunction

   function automatic logic [16:0] dut_vec();
      return {state, pll_resetn, clk_en, periph_resetn, core_resetn, relock_ack, fail, lost_count};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in1);
      if (resetn) model_edge();
      @(negedge clk_in1);
      check("model", 32'(dut_vec()), 32'(model_vec()));
   endtask

   task automatic reset_now(input string name);
      resetn = 1'b0;
      relock_req = 1'b0;
      model_reset();
      #1;
      check(name, 32'(dut_vec()), 32'h0);
   endtask

   task automatic do_reset();
      @(negedge clk_in1);
      reset_now("reset_vals");
      @(negedge clk_in1);
      resetn = 1'b1;
   endtask

   task automatic run_until(input int ph, input int budget, output int acks, output bit ok);
      acks = 0;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (relock_ack) acks++;
         if (state == 3'(ph)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   typedef struct {
      int       n;
      bit       lk;
      bit [2:0] st;
      bit [4:0] outs;  // {pll_resetn, clk_en, periph_resetn, core_resetn, fail}
      int       lost;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int n, input bit lk, input bit [2:0] st, input bit [4:0] outs,
                      input int lost);
      vec_t v;
      v.n = n; v.lk = lk; v.st = st; v.outs = outs; v.lost = lost;
      tbl.push_back(v);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  acks;
      bit  ok;
      int  len;

      model_reset();
      // Clean start, then loss in RUN, then a 2-cycle glitch during STABLE.
      add(3, 0, 3'd0, 5'b00000, 0);
      add(1, 0, 3'd1, 5'b10000, 0);
      add(2, 1, 3'd1, 5'b10000, 0);
      add(1, 1, 3'd2, 5'b10000, 0);
      add(7, 1, 3'd2, 5'b10000, 0);
      add(1, 1, 3'd3, 5'b11100, 0);
      add(2, 1, 3'd3, 5'b11100, 0);
      add(1, 1, 3'd4, 5'b11110, 0);
      add(2, 0, 3'd4, 5'b11110, 0);
      add(1, 0, 3'd0, 5'b00000, 1);
      add(3, 0, 3'd0, 5'b00000, 1);
      add(1, 0, 3'd1, 5'b10000, 1);
      add(3, 1, 3'd2, 5'b10000, 1);
      add(2, 1, 3'd2, 5'b10000, 1);
      add(2, 0, 3'd2, 5'b10000, 1);
      add(2, 1, 3'd1, 5'b10000, 1);
      add(1, 1, 3'd2, 5'b10000, 1);
      add(7, 1, 3'd2, 5'b10000, 1);
      add(1, 1, 3'd3, 5'b11100, 1);
      add(3, 1, 3'd4, 5'b11110, 1);

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         locked = tbl[i].lk;
         repeat (tbl[i].n) tick();
         check($sformatf("tbl%0d", i),
               32'({state, pll_resetn, clk_en, periph_resetn, core_resetn, fail, lost_count}),
               32'({tbl[i].st, tbl[i].outs, 8'(tbl[i].lost)}));
      end

      // Relock request in the same cycle the synchronized lock drops.
      locked = 1'b0;
      repeat (2) tick();
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      check("loss_relock_state", 32'(state), 32'(PH_RST));
      check("loss_relock_lost", 32'(lost_count), 32'd2);
      locked = 1'b1;
      run_until(PH_RUN, 60, acks, ok);
      check("loss_relock_run", 32'(ok), 32'd1);
      repeat (5) begin
         tick();
         if (relock_ack) acks++;
      end
      check("loss_relock_acks", 32'(acks), 32'd1);

      // Force 300 losses; the counter must saturate.
      for (int i = 0; i < 300; i++) begin
         locked = 1'b0;
         run_until(PH_RST, 10, acks, ok);
         if (!ok) check("sat_loss_bound", 32'(ok), 32'd1);
         locked = 1'b1;
         run_until(PH_RUN, 60, acks, ok);
         if (!ok) check("sat_run_bound", 32'(ok), 32'd1);
      end
      check("lost_saturated", 32'(lost_count), 32'd255);

      // Asynchronous reset in the middle of RELEASE.
      locked = 1'b0;
      run_until(PH_RST, 10, acks, ok);
      locked = 1'b1;
      run_until(PH_REL, 60, acks, ok);
      check("reach_release", 32'(ok), 32'd1);
      tick();
      reset_now("reset_mid_release");
      @(negedge clk_in1);
      resetn = 1'b1;

      // Lock never comes: two timeouts then sticky FAIL; relock recovers.
      locked = 1'b0;
      repeat (P + T + P + T - 1) tick();
      check("before_fail_state", 32'(state), 32'(PH_WAIT));
      tick();
      check("fail_state", 32'({state, fail, pll_resetn}), 32'({3'(PH_FAIL), 1'b1, 1'b0}));
      locked = 1'b1;
      repeat (10) tick();
      check("fail_sticky", 32'({state, fail}), 32'({3'(PH_FAIL), 1'b1}));
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      check("fail_cleared", 32'({state, fail}), 32'({3'(PH_RST), 1'b0}));
      run_until(PH_RUN, 60, acks, ok);
      check("fail_recover_run", 32'(ok), 32'd1);
      check("fail_recover_acks", 32'(acks), 32'd1);

      // Random lock activity and relock pulses against the model.
      for (int seg = 0; seg < 60; seg++) begin
         if ($urandom_range(0, 19) == 0) do_reset();
         locked = ($urandom_range(0, 3) != 0);
         len = $urandom_range(1, 40);
         for (int k = 0; k < len; k++) begin
            relock_req = ($urandom_range(0, 15) == 0);
            tick();
            relock_req = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/clk_lock_rst_seq.md
# clk_lock_rst_seq

Reset and lock sequencer for the 2x clock generator (100 MHz in, 200 MHz out). Runs on the 100 MHz input clock, drives the generator's reset, qualifies its `locked` output, and releases downstream resets in a fixed, staggered order. It recovers from lock loss and retries a failed lock a bounded number of times before declaring a sticky failure.

## Interface

Parameters:
- `PLL_RST_CYCLES`, default 16: cycles `pll_resetn` is held low per attempt.
- `LOCK_TIMEOUT`, default 4096: cycles allowed in WAIT_LOCK before an attempt fails.
- `STABLE_CYCLES`, default 256: consecutive synchronized-locked cycles required before release.
- `STAGGER_CYCLES`, default 8: cycles between `periph_resetn` rise and `core_resetn` rise.
- `RETRY_MAX`, default 3: failed attempts allowed before FAIL.

Ports:
- `clk_in1`  in  1  100 MHz reference clock; all logic in this domain.
- `resetn`  in  1  asynchronous, active-low reset.
- `locked`  in  1  generator lock flag; asynchronous; 2-flop synchronized to `locked_s`.
- `relock_req`  in  1  single-cycle request to re-run the full sequence.
- `pll_resetn`  out  1  generator reset, active low.
- `clk_en`  out  1  enable for the 200 MHz domain clock gate.
- `periph_resetn`  out  1  peripheral-domain reset, active low.
- `core_resetn`  out  1  core-domain reset, active low.
- `relock_ack`  out  1  one-cycle pulse on RUN entry after a relock request.
- `fail`  out  1  sticky retry-exhausted flag.
- `lost_count`  out  8  lock-loss events seen in RELEASE/RUN; saturates at 255.
- `state`  out  3  current state encoding, for debug.

## Operation

- Reset values: `pll_resetn`=0, `clk_en`=0, `periph_resetn`=0, `core_resetn`=0, `relock_ack`=0, `fail`=0, `lost_count`=0, `state`=PLL_RST. Retry counter and pending flag are 0.
- Outputs are registered and decoded from the next state.
- PLL_RST: `pll_resetn`=0 and all downstream resets asserted. After `PLL_RST_CYCLES` cycles, go to WAIT_LOCK.
- WAIT_LOCK: `pll_resetn`=1; timeout counter runs.
  - `locked_s`=1: go to STABLE.
  - Timeout counter reaches `LOCK_TIMEOUT`: increment retry. If retry equals `RETRY_MAX`, go to FAIL; otherwise go to PLL_RST.
- STABLE: stability counter runs while `locked_s`=1.
  - `locked_s`=0: go to WAIT_LOCK with a fresh timeout. This is not counted as a loss.
  - `STABLE_CYCLES` consecutive high cycles: go to RELEASE.
- RELEASE:
  - On entry, `clk_en`=1 and `periph_resetn`=1.
  - `STAGGER_CYCLES` later, `core_resetn`=1, and the block goes to RUN.
- RUN: all releases held. Retry counter cleared on entry. If the pending flag is set, pulse `relock_ack` and clear pending.
- Lock loss (`locked_s`=0 in RELEASE or RUN):
  - `lost_count` += 1, saturating at 255.
  - The next cycle has all resets asserted and `clk_en`=0.
  - Go to PLL_RST.
- `relock_req`:
  - In RUN: set pending and go to PLL_RST.
  - In PLL_RST, WAIT_LOCK, STABLE or RELEASE: set pending only; the sequence continues.
  - In FAIL: clear `fail` and retry, set pending, go to PLL_RST.
- FAIL: `pll_resetn`=0, all downstream resets asserted, `fail`=1. Only `resetn` or `relock_req` leaves this state.
- Lock loss and `relock_req` in the same cycle: take the loss path and also set pending.

## Timing

- `locked` to `locked_s` latency: 2 clocks.
- After `resetn` deasserts, `pll_resetn` stays low for exactly `PLL_RST_CYCLES` clocks.
- From the first `locked_s`=1 cycle, with lock held:
  - `periph_resetn` and `clk_en` rise `STABLE_CYCLES`+1 clocks later.
  - `core_resetn` rises `STAGGER_CYCLES` clocks after `periph_resetn`.
- Loss in RUN: downstream resets assert 1 clock after `locked_s` falls, which is 3 clocks after raw `locked` falls.
- `relock_ack` is asserted for exactly 1 clock.
- Asserting `resetn` in any state forces the reset values asynchronously. `lost_count` is also cleared.

## Structure

- Package `clk_seq_pkg`: `clk_seq_state_e` enum (PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4, FAIL=5) and `LOST_W`=8.
- Sub-module `clk_seq_sync2`: 2-flop synchronizer with async active-low reset to 0. Used for `locked`.
- One shared down-counter, reloaded on every state change.

## Test plan

Use `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=32, `STABLE_CYCLES`=8, `STAGGER_CYCLES`=3, `RETRY_MAX`=2.

- Clean start, `locked` high 10 clocks after reset:
  - `pll_resetn` low for 4 clocks.
  - `periph_resetn` and `clk_en` rise 11 clocks after `locked`.
  - `core_resetn` rises 3 clocks later; `state`=RUN.
- Glitch: `locked` drops for 2 clocks during STABLE → back to WAIT_LOCK, `lost_count`=0, stability counting restarts.
- Loss in RUN: `locked` drops → resets asserted 3 clocks later, `lost_count`=1, full sequence reruns.
- `locked` never rises → two 32-clock timeouts, then `fail`=1 and `pll_resetn`=0. A later `relock_req` with `locked`=1 reaches RUN and pulses `relock_ack` once.
- `relock_req` in RUN, same cycle as a `locked` drop → `lost_count` +1, exactly one `relock_ack` on re-entry to RUN.
- 300 forced losses → `lost_count` stays at 255; `resetn` mid-RELEASE → all outputs at reset values immediately.
